// File: rtl/bram_nrport_1wport_pkg.sv
// Shared types and helpers for the multi-read-port BRAM.
package bram_nrport_1wport_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } collision_mode_t;

    typedef logic [0:0] clr_state_t;
    localparam clr_state_t CLR_IDLE   = 1'b0;
    localparam clr_state_t CLR_ACTIVE = 1'b1;

    function automatic int idx_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/bram_nrport_1wport_if.sv
// Read/write bus of the multi-read-port BRAM; master drives requests, slave is the memory.
interface bram_nrport_1wport_if #(
    parameter int NUM_RPORTS  = 2,
    parameter int INNER_WIDTH = 32,
    parameter int IDX_W       = 5
);
    logic [NUM_RPORTS-1:0]                  rport_ren;
    logic [NUM_RPORTS-1:0][IDX_W-1:0]       rport_rindex;
    logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] rport_rdata;
    logic [NUM_RPORTS-1:0]                  rport_rvalid;
    logic [INNER_WIDTH/8-1:0]               wen_byte;
    logic [IDX_W-1:0]                       windex;
    logic [INNER_WIDTH-1:0]                 wdata;
    logic                                   init_busy;

    modport master (
        output rport_ren, rport_rindex, wen_byte, windex, wdata,
        input  rport_rdata, rport_rvalid, init_busy
    );

    modport slave (
        input  rport_ren, rport_rindex, wen_byte, windex, wdata,
        output rport_rdata, rport_rvalid, init_busy
    );
endinterface

// File: rtl/bram_rport_pipe.sv
// One read port: same-cycle write merge followed by an RD_LATENCY-deep data/valid pipeline.
module bram_rport_pipe
    import bram_nrport_1wport_pkg::*;
#(
    parameter int              INNER_WIDTH    = 32,
    parameter int              IDX_W          = 5,
    parameter int              RD_LATENCY     = 1,
    parameter collision_mode_t COLLISION_MODE = READ_FIRST
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ren_i,
    input  logic [IDX_W-1:0]         rindex_i,
    input  logic [INNER_WIDTH-1:0]   old_i,
    input  logic [INNER_WIDTH/8-1:0] wen_byte_i,
    input  logic [IDX_W-1:0]         windex_i,
    input  logic [INNER_WIDTH-1:0]   wdata_i,
    output logic [INNER_WIDTH-1:0]   rdata_o,
    output logic                     rvalid_o
);
    localparam int NB = INNER_WIDTH / 8;

    logic [INNER_WIDTH-1:0]                 merged_d;
    logic [RD_LATENCY-1:0]                  vld_q;
    logic [RD_LATENCY-1:0][INNER_WIDTH-1:0] dat_q;
    logic [RD_LATENCY:0]                    vld_pipe;
    logic [RD_LATENCY:0][INNER_WIDTH-1:0]   dat_pipe;

    // wen_byte_i is already zero for dropped writes, so no extra qualification here.
    always_comb begin
        merged_d = old_i;
        if (COLLISION_MODE == WRITE_FIRST && rindex_i == windex_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wen_byte_i[b]) merged_d[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    assign vld_pipe = {vld_q, ren_i};
    assign dat_pipe = {dat_q, merged_d};

    // Data only advances behind a valid so the output holds between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_pipe[RD_LATENCY-1:0];
            for (int s = 0; s < RD_LATENCY; s++) begin
                if (vld_pipe[s]) dat_q[s] <= dat_pipe[s];
            end
        end
    end

    assign rdata_o  = dat_pipe[RD_LATENCY];
    assign rvalid_o = vld_pipe[RD_LATENCY];

endmodule

// File: rtl/bram_nrport_1wport.sv
// N registered read ports, one byte-enabled write port, post-reset clear sequencer.
// INIT_FILE images are loaded by the implementation memory-init flow; here a non-empty name only disables the clear.
module bram_nrport_1wport
    import bram_nrport_1wport_pkg::*;
#(
    parameter int              INNER_WIDTH    = 32,
    parameter int              OUTER_WIDTH    = 32,
    parameter int              NUM_RPORTS     = 2,
    parameter int              RD_LATENCY     = 1,
    parameter collision_mode_t COLLISION_MODE = READ_FIRST,
    parameter int              CLEAR_ON_RESET = 1,
    parameter string           INIT_FILE      = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bram_nrport_1wport_if.slave  bus
);
    localparam int                IDX_W    = idx_width(OUTER_WIDTH);
    localparam int                NB       = INNER_WIDTH / 8;
    localparam bit                CLEAR_EN = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OUTER_WIDTH - 1);

    logic [INNER_WIDTH-1:0] mem_q [OUTER_WIDTH];

    clr_state_t             state_q, state_d;
    logic [IDX_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                   busy;
    logic                   w_in;
    logic [NUM_RPORTS-1:0]  r_in;
    logic [NUM_RPORTS-1:0]  ren_eff;
    logic [NB-1:0]          wen_eff;

    logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] rdata_w;
    logic [NUM_RPORTS-1:0]                  rvalid_w;

    // ---------------- clear sequencer ----------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLR_ACTIVE) begin
            if (clr_cnt_q == LAST_IDX) state_d = CLR_IDLE;
            else                       clr_cnt_d = clr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR_EN ? CLR_ACTIVE : CLR_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy          = (state_q == CLR_ACTIVE);
    assign bus.init_busy = busy;

    // Index range checks vanish when the depth is a power of two.
    if (OUTER_WIDTH == (1 << IDX_W)) begin : g_full
        assign w_in = 1'b1;
        assign r_in = '1;
    end else begin : g_part
        assign w_in = (bus.windex <= LAST_IDX);
        for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_r
            assign r_in[p] = (bus.rport_rindex[p] <= LAST_IDX);
        end
    end

    assign wen_eff = (!busy && w_in) ? bus.wen_byte : '0;
    assign ren_eff = busy ? '0 : bus.rport_ren;

    // ---------------- array: not touched by reset ----------------
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wen_eff[b]) mem_q[bus.windex][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        logic [INNER_WIDTH-1:0] old_data;
        assign old_data = r_in[p] ? mem_q[bus.rport_rindex[p]] : '0;

        bram_rport_pipe #(
            .INNER_WIDTH    (INNER_WIDTH),
            .IDX_W          (IDX_W),
            .RD_LATENCY     (RD_LATENCY),
            .COLLISION_MODE (COLLISION_MODE)
        ) u_pipe (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .ren_i      (ren_eff[p]),
            .rindex_i   (bus.rport_rindex[p]),
            .old_i      (old_data),
            .wen_byte_i (wen_eff),
            .windex_i   (bus.windex),
            .wdata_i    (bus.wdata),
            .rdata_o    (rdata_w[p]),
            .rvalid_o   (rvalid_w[p])
        );
    end

    assign bus.rport_rdata  = rdata_w;
    assign bus.rport_rvalid = rvalid_w;

endmodule

// File: tb/tb_bram_nrport_1wport.sv
// Directed bench: A = 16x32, 4 ports, LAT1, READ_FIRST; B = 12x32, 2 ports, LAT2, WRITE_FIRST.
module tb_bram_nrport_1wport;
    import bram_nrport_1wport_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_tot = 0;
    int   n_bad = 0;
    int   ca, cb;
    logic rv_any;
    logic [31:0] exp_b [12];

    always #5 clk = ~clk;

    bram_nrport_1wport_if #(.NUM_RPORTS(4), .INNER_WIDTH(32), .IDX_W(4)) ifa ();
    bram_nrport_1wport_if #(.NUM_RPORTS(2), .INNER_WIDTH(32), .IDX_W(4)) ifb ();

    bram_nrport_1wport #(
        .INNER_WIDTH(32), .OUTER_WIDTH(16), .NUM_RPORTS(4), .RD_LATENCY(1),
        .COLLISION_MODE(READ_FIRST), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u_a (.clk_i(clk), .rst_i(rst_a), .bus(ifa));

    bram_nrport_1wport #(
        .INNER_WIDTH(32), .OUTER_WIDTH(12), .NUM_RPORTS(2), .RD_LATENCY(2),
        .COLLISION_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u_b (.clk_i(clk), .rst_i(rst_b), .bus(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr_a(input logic [3:0] idx, input logic [3:0] be, input logic [31:0] d);
        ifa.windex = idx; ifa.wen_byte = be; ifa.wdata = d;
        tick();
        ifa.wen_byte = '0;
    endtask

    task automatic wr_b(input logic [3:0] idx, input logic [3:0] be, input logic [31:0] d);
        ifb.windex = idx; ifb.wen_byte = be; ifb.wdata = d;
        tick();
        ifb.wen_byte = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.rport_ren = '0; ifa.rport_rindex = '0; ifa.wen_byte = '0; ifa.windex = '0; ifa.wdata = '0;
        ifb.rport_ren = '0; ifb.rport_rindex = '0; ifb.wen_byte = '0; ifb.windex = '0; ifb.wdata = '0;
        tick();
        rst_a = 1'b0; rst_b = 1'b0;

        chk("rst_rdata_a",  ifa.rport_rdata[0], 32'h0);
        chk("rst_rvalid_a", 32'(ifa.rport_rvalid), 32'h0);
        chk("rst_rvalid_b", 32'(ifb.rport_rvalid), 32'h0);
        chk("busy_set_a",   32'(ifa.init_busy), 32'h1);
        chk("busy_set_b",   32'(ifb.init_busy), 32'h1);

        // reads and a write to entry 5 held through the whole clear window
        ifa.rport_ren = '1; ifa.windex = 4'd5; ifa.wen_byte = '1; ifa.wdata = 32'hFFFF_FFFF;
        ca = 0; cb = 0; rv_any = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rv_any |= |ifa.rport_rvalid;
            if (ifa.init_busy) ca++;
            else begin ifa.rport_ren = '0; ifa.wen_byte = '0; end
            if (ifb.init_busy) cb++;
            tick();
        end
        chk("busy_len_a", 32'(ca), 32'd16);
        chk("busy_len_b", 32'(cb), 32'd12);
        chk("ren_ignored_busy", 32'(rv_any), 32'h0);

        for (int c = 0; c < 4; c++) begin
            ifa.rport_ren = '1;
            for (int p = 0; p < 4; p++) ifa.rport_rindex[p] = 4'(c*4 + p);
            tick();
            for (int p = 0; p < 4; p++) chk($sformatf("clr_a[%0d]", c*4 + p), ifa.rport_rdata[p], 32'h0);
            chk("clr_rvalid_a", 32'(ifa.rport_rvalid), 32'hF);
        end
        ifa.rport_ren = '0;

        // latency 1
        wr_a(4'd5, 4'hF, 32'hDEAD_BEEF);
        ifa.rport_ren = 4'b0001; ifa.rport_rindex[0] = 4'd5;
        tick();
        chk("lat1_data", ifa.rport_rdata[0], 32'hDEAD_BEEF);
        chk("lat1_vld",  32'(ifa.rport_rvalid[0]), 32'h1);
        ifa.rport_ren = '0;
        tick();
        chk("hold_data_a", ifa.rport_rdata[0], 32'hDEAD_BEEF);
        chk("hold_vld_a",  32'(ifa.rport_rvalid[0]), 32'h0);

        // latency 2
        wr_b(4'd5, 4'hF, 32'hDEAD_BEEF);
        ifb.rport_ren = 2'b01; ifb.rport_rindex[0] = 4'd5;
        tick();
        chk("lat2_vld_early",  32'(ifb.rport_rvalid[0]), 32'h0);
        chk("lat2_data_early", ifb.rport_rdata[0], 32'h0);
        ifb.rport_ren = '0;
        tick();
        chk("lat2_data", ifb.rport_rdata[0], 32'hDEAD_BEEF);
        chk("lat2_vld",  32'(ifb.rport_rvalid[0]), 32'h1);
        tick();
        chk("hold_data_b", ifb.rport_rdata[0], 32'hDEAD_BEEF);
        chk("hold_vld_b",  32'(ifb.rport_rvalid[0]), 32'h0);

        // collision, READ_FIRST
        wr_a(4'd3, 4'hF, 32'h1122_3344);
        ifa.windex = 4'd3; ifa.wen_byte = 4'b0101; ifa.wdata = 32'hAABB_CCDD;
        ifa.rport_ren = 4'b0001; ifa.rport_rindex[0] = 4'd3;
        tick();
        chk("coll_rf", ifa.rport_rdata[0], 32'h1122_3344);
        ifa.wen_byte = '0;
        tick();
        chk("coll_rf_after", ifa.rport_rdata[0], 32'h11BB_33DD);
        ifa.rport_ren = '0;

        // collision, WRITE_FIRST, both ports on the written index
        wr_b(4'd3, 4'hF, 32'h1122_3344);
        ifb.windex = 4'd3; ifb.wen_byte = 4'b0101; ifb.wdata = 32'hAABB_CCDD;
        ifb.rport_ren = 2'b11; ifb.rport_rindex[0] = 4'd3; ifb.rport_rindex[1] = 4'd3;
        tick();
        ifb.wen_byte = '0; ifb.rport_ren = '0;
        tick();
        chk("coll_wf_p0", ifb.rport_rdata[0], 32'h11BB_33DD);
        chk("coll_wf_p1", ifb.rport_rdata[1], 32'h11BB_33DD);

        // back-to-back LAT2 reads
        ifb.rport_ren = 2'b01; ifb.rport_rindex[0] = 4'd5;
        tick();
        ifb.rport_rindex[0] = 4'd3;
        tick();
        chk("b2b_d0", ifb.rport_rdata[0], 32'hDEAD_BEEF);
        chk("b2b_v0", 32'(ifb.rport_rvalid[0]), 32'h1);
        ifb.rport_ren = '0;
        tick();
        chk("b2b_d1", ifb.rport_rdata[0], 32'h11BB_33DD);
        chk("b2b_v1", 32'(ifb.rport_rvalid[0]), 32'h1);
        tick();
        chk("b2b_v2", 32'(ifb.rport_rvalid[0]), 32'h0);

        // four ports in one cycle
        wr_a(4'd0, 4'hF, 32'hA0A0_A0A0);
        wr_a(4'd1, 4'hF, 32'hB1B1_B1B1);
        wr_a(4'd7, 4'hF, 32'hC7C7_C7C7);
        ifa.rport_ren = '1;
        ifa.rport_rindex[0] = 4'd0; ifa.rport_rindex[1] = 4'd1;
        ifa.rport_rindex[2] = 4'd1; ifa.rport_rindex[3] = 4'd7;
        tick();
        chk("mp0", ifa.rport_rdata[0], 32'hA0A0_A0A0);
        chk("mp1", ifa.rport_rdata[1], 32'hB1B1_B1B1);
        chk("mp2", ifa.rport_rdata[2], 32'hB1B1_B1B1);
        chk("mp3", ifa.rport_rdata[3], 32'hC7C7_C7C7);
        ifa.rport_ren = '0;

        // reset mid-clear at clr_cnt = 9
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("rst2_rdata_a", ifa.rport_rdata[0], 32'h0);
        chk("rst2_busy_a",  32'(ifa.init_busy), 32'h1);
        for (int i = 0; i < 9; i++) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        ifa.windex = 4'd7; ifa.wen_byte = '1; ifa.wdata = 32'h1234_5678;
        ca = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifa.init_busy) ca++;
            else ifa.wen_byte = '0;
            tick();
        end
        chk("midclr_len", 32'(ca), 32'd16);
        ifa.rport_ren = '1;
        ifa.rport_rindex[0] = 4'd0; ifa.rport_rindex[1] = 4'd1;
        ifa.rport_rindex[2] = 4'd7; ifa.rport_rindex[3] = 4'd5;
        tick();
        for (int p = 0; p < 4; p++) chk($sformatf("midclr_rd%0d", p), ifa.rport_rdata[p], 32'h0);
        ifa.rport_ren = '0;

        // out-of-range read and write on the 12-entry instance
        ifb.rport_ren = 2'b01; ifb.rport_rindex[0] = 4'd13;
        ifb.windex = 4'd14; ifb.wen_byte = '1; ifb.wdata = 32'hFFFF_FFFF;
        tick();
        ifb.rport_ren = '0; ifb.wen_byte = '0;
        tick();
        chk("oob_rd_data", ifb.rport_rdata[0], 32'h0);
        chk("oob_rd_vld",  32'(ifb.rport_rvalid[0]), 32'h1);

        foreach (exp_b[i]) exp_b[i] = 32'h0;
        exp_b[3] = 32'h11BB_33DD;
        exp_b[5] = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            ifb.rport_ren = 2'b11;
            ifb.rport_rindex[0] = 4'(2*c);
            ifb.rport_rindex[1] = 4'(2*c + 1);
            tick();
            ifb.rport_ren = '0;
            tick();
            chk($sformatf("oob_keep[%0d]", 2*c),     ifb.rport_rdata[0], exp_b[2*c]);
            chk($sformatf("oob_keep[%0d]", 2*c + 1), ifb.rport_rdata[1], exp_b[2*c + 1]);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
